// File: rtl/i2c_master_core_if.sv
// ============================================================================
// Module : i2c_master_core_if
// Brief  : MMIO slot bus between the FPro MMIO controller and an I/O core.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface i2c_master_core_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (output cs, read, write, addr, wr_data, input rd_data);
  modport slave  (input cs, read, write, addr, wr_data, output rd_data);
endinterface

`default_nettype wire

// File: rtl/i2c_master_core.sv
// ============================================================================
// Module : i2c_master_core
// Brief  : I2C master slot core; executes one START/WR/RD/STOP/RESTART at a time.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module i2c_master_core (
  input  logic               clk,
  input  logic               reset,
  i2c_master_core_if.slave   bus,
  inout  wire                scl,
  inout  wire                sda
);

  localparam logic [2:0] CMD_START   = 3'd0;
  localparam logic [2:0] CMD_WR      = 3'd1;
  localparam logic [2:0] CMD_RD      = 3'd2;
  localparam logic [2:0] CMD_STOP    = 3'd3;
  localparam logic [2:0] CMD_RESTART = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE, S_START1, S_START2, S_HOLD,
    S_DATA1, S_DATA2, S_DATA3, S_DATA4, S_DATA_END,
    S_RESTART, S_STOP1, S_STOP2
  } state_t;

  state_t      state_q;
  logic [15:0] dvsr_q;
  logic [15:0] c_q;
  logic [3:0]  bit_q;
  logic [8:0]  tx_q;
  logic [8:0]  rx_q;
  logic [7:0]  dout_q;
  logic        ack_q;
  logic        scl_q;
  logic        sda_q;
  logic [1:0]  sync_q;

  logic        wr_en;
  logic        cmd_go;
  logic        ready;
  logic        phase_end;
  logic [15:0] lim;
  logic [2:0]  new_cmd;
  logic [7:0]  new_din;
  logic        unused_bits;

  assign wr_en     = bus.cs & bus.write;
  assign ready     = (state_q == S_IDLE) || (state_q == S_HOLD);
  assign cmd_go    = wr_en && (bus.addr == 5'd2) && ready;
  assign new_cmd   = bus.wr_data[10:8];
  assign new_din   = bus.wr_data[7:0];
  // dvsr=0 collapses to a one-clock phase; >= tolerates dvsr shrinking mid-phase
  assign lim       = (dvsr_q == 16'd0) ? 16'd0 : dvsr_q - 16'd1;
  assign phase_end = (c_q >= lim);

  assign bus.rd_data = {22'b0, ready, ack_q, dout_q};
  assign scl = scl_q ? 1'bz : 1'b0;
  assign sda = sda_q ? 1'bz : 1'b0;
  assign unused_bits = &{1'b0, bus.read, bus.wr_data[31:16]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      dvsr_q <= 16'd0;
      sync_q <= 2'b11;
    end else begin
      if (wr_en && (bus.addr == 5'd1)) dvsr_q <= bus.wr_data[15:0];
      sync_q <= {sync_q[0], sda};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      c_q     <= 16'd0;
      bit_q   <= 4'd0;
      tx_q    <= 9'h1FF;
      rx_q    <= 9'd0;
      dout_q  <= 8'd0;
      ack_q   <= 1'b0;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
    end else begin
      if (ready || phase_end) c_q <= 16'd0;
      else                    c_q <= c_q + 16'd1;

      case (state_q)
        S_IDLE: begin
          if (cmd_go && (new_cmd == CMD_START)) begin
            state_q <= S_START1;
            sda_q   <= 1'b0;
          end
        end
        S_START1: if (phase_end) begin state_q <= S_START2; scl_q <= 1'b0; end
        S_START2: if (phase_end) state_q <= S_HOLD;
        S_HOLD: begin
          if (cmd_go) begin
            case (new_cmd)
              CMD_START, CMD_RESTART: begin
                state_q <= S_RESTART;
                scl_q   <= 1'b1;
                sda_q   <= 1'b1;
              end
              CMD_WR: begin
                state_q <= S_DATA1;
                bit_q   <= 4'd0;
                tx_q    <= {new_din, 1'b1};
                sda_q   <= new_din[7];
              end
              CMD_RD: begin
                state_q <= S_DATA1;
                bit_q   <= 4'd0;
                tx_q    <= {8'hFF, new_din[0]};
                sda_q   <= 1'b1;
              end
              CMD_STOP: begin
                state_q <= S_STOP1;
                sda_q   <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        S_DATA1: if (phase_end) begin state_q <= S_DATA2; scl_q <= 1'b1; end
        S_DATA2: begin
          // mid-bit with SCL high: capture the synchronized line
          if (phase_end) begin
            state_q <= S_DATA3;
            rx_q    <= {rx_q[7:0], sync_q[1]};
          end
        end
        S_DATA3: if (phase_end) begin state_q <= S_DATA4; scl_q <= 1'b0; end
        S_DATA4: begin
          if (phase_end) begin
            if (bit_q == 4'd8) begin
              state_q <= S_DATA_END;
            end else begin
              state_q <= S_DATA1;
              bit_q   <= bit_q + 4'd1;
              tx_q    <= {tx_q[7:0], 1'b1};
              sda_q   <= tx_q[7];
            end
          end
        end
        S_DATA_END: begin
          if (phase_end) begin
            state_q <= S_HOLD;
            dout_q  <= rx_q[8:1];
            ack_q   <= rx_q[0];
          end
        end
        S_RESTART: if (phase_end) begin state_q <= S_START1; sda_q <= 1'b0; end
        S_STOP1:   if (phase_end) begin state_q <= S_STOP2;  scl_q <= 1'b1; end
        S_STOP2:   if (phase_end) begin state_q <= S_IDLE;   sda_q <= 1'b1; end
        default: begin
          state_q <= S_IDLE;
          scl_q   <= 1'b1;
          sda_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i2c_master_core.sv
// ============================================================================
// Module : tb_i2c_master_core
// Brief  : Self-checking bench for i2c_master_core with an I2C slave model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_i2c_master_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic slv_pull;
  wire  scl;
  wire  sda;

  i2c_master_core_if bus ();

  pullup pu_scl (scl);
  pullup pu_sda (sda);
  assign sda = slv_pull ? 1'b0 : 1'bz;

  i2c_master_core dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus),
    .scl   (scl),
    .sda   (sda)
  );

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.cs = 1'b1; bus.write = 1'b1; bus.addr = a; bus.wr_data = d;
    @(posedge clk);
    #1;
    bus.cs = 1'b0; bus.write = 1'b0;
  endtask

  task automatic count_ready_low(output int n, output bit tout);
    n = 0; tout = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (bus.rd_data[9]) begin tout = 1'b0; break; end
      n++;
    end
  endtask

  // Runs one byte command; the slave drives sbyte (RD) and pulls ack when sack=1.
  task automatic xfer(input logic [2:0] cmd, input logic [7:0] din, input logic [7:0] sbyte,
                      input logic sack, output logic [8:0] bits, output int rlow, output bit tout);
    int   highs;
    logic ps;
    highs = 0; bits = '0; rlow = 0; tout = 1'b1; ps = scl;
    slv_pull = (cmd == 3'd2) ? ~sbyte[7] : 1'b0;
    write_reg(5'd2, {21'b0, cmd, din});
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (bus.rd_data[9]) begin tout = 1'b0; break; end
      rlow++;
      if (!ps && scl) begin
        if (highs < 9) bits[8-highs] = sda;
        highs++;
      end
      if (ps && !scl) begin
        if (highs < 8)       slv_pull = (cmd == 3'd2) ? ~sbyte[7-highs] : 1'b0;
        else if (highs == 8) slv_pull = sack;
        else                 slv_pull = 1'b0;
      end
      ps = scl;
    end
    slv_pull = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (scl !== 1'b1) begin errors++; $display("FAIL reset_scl got %b want 1", scl); end
    checks++; if (sda !== 1'b1) begin errors++; $display("FAIL reset_sda got %b want 1", sda); end
    checks++; if (bus.rd_data !== 32'h0000_0200) begin errors++; $display("FAIL reset_rd got %h want 00000200", bus.rd_data); end
    rst_n = 1'b1;
  endtask

  task automatic test_start;
    int t_sda, t_scl, n, e;
    bit tout;
    t_sda = 0; t_scl = 0; n = 0; tout = 1'b1;
    write_reg(5'd1, 32'd4);
    exp_q.push_back(4);
    exp_q.push_back(8);
    write_reg(5'd2, {21'b0, 3'd0, 8'h00});
    for (int i = 1; i < 100; i++) begin
      @(negedge clk);
      if (sda === 1'b0 && t_sda == 0) t_sda = i;
      if (scl === 1'b0 && t_scl == 0) t_scl = i;
      if (bus.rd_data[9]) begin tout = 1'b0; break; end
      n++;
    end
    checks++; if (tout) begin errors++; $display("FAIL start_timeout got timeout want ready"); end
    e = exp_q.pop_front();
    checks++; if (t_scl - t_sda !== e) begin errors++; $display("FAIL start_gap got %0d want %0d", t_scl - t_sda, e); end
    e = exp_q.pop_front();
    checks++; if (n !== e) begin errors++; $display("FAIL start_ready_low got %0d want %0d", n, e); end
  endtask

  task automatic test_wr;
    logic [8:0] bits;
    int rlow, e;
    bit tout;
    for (int k = 7; k >= 0; k--) exp_q.push_back(int'(8'hA5 >> k) & 1);
    exp_q.push_back(0);
    exp_q.push_back(148);
    xfer(3'd1, 8'hA5, 8'hFF, 1'b1, bits, rlow, tout);
    checks++; if (tout) begin errors++; $display("FAIL wr_timeout got timeout want ready"); end
    for (int k = 8; k >= 0; k--) begin
      e = exp_q.pop_front();
      checks++; if (int'(bits[k]) !== e) begin errors++; $display("FAIL wr_bit%0d got %b want %0d", 8-k, bits[k], e); end
    end
    e = exp_q.pop_front();
    checks++; if (rlow !== e) begin errors++; $display("FAIL wr_duration got %0d want %0d", rlow, e); end
    checks++; if (bus.rd_data[9:8] !== 2'b10) begin errors++; $display("FAIL wr_status got %b want 10", bus.rd_data[9:8]); end
    checks++; if (bus.rd_data[7:0] !== 8'hA5) begin errors++; $display("FAIL wr_dout got %h want a5", bus.rd_data[7:0]); end
  endtask

  task automatic test_rd;
    logic [8:0] bits;
    int rlow;
    bit tout;
    exp_q.push_back(9'h079);
    exp_q.push_back(32'h0000_033C);
    xfer(3'd2, 8'h01, 8'h3C, 1'b0, bits, rlow, tout);
    checks++; if (tout) begin errors++; $display("FAIL rd_timeout got timeout want ready"); end
    checks++; if (int'(bits) !== exp_q[0]) begin errors++; $display("FAIL rd_line got %h want %h", bits, exp_q[0]); end
    void'(exp_q.pop_front());
    checks++; if (bus.rd_data !== exp_q[0]) begin errors++; $display("FAIL rd_status got %h want %h", bus.rd_data, exp_q[0]); end
    void'(exp_q.pop_front());
  endtask

  task automatic test_stop;
    int t_scl, t_sda, bad, e;
    t_scl = 0; t_sda = 0; bad = 0;
    exp_q.push_back(4);
    write_reg(5'd2, {21'b0, 3'd3, 8'h00});
    for (int i = 1; i < 100; i++) begin
      @(negedge clk);
      if (scl === 1'b1 && t_scl == 0) t_scl = i;
      if (scl === 1'b1 && sda === 1'b1 && t_sda == 0) begin t_sda = i; break; end
    end
    e = exp_q.pop_front();
    checks++; if (t_sda == 0 || t_sda - t_scl !== e) begin errors++; $display("FAIL stop_gap got %0d want %0d", t_sda - t_scl, e); end
    checks++; if (bus.rd_data[9] !== 1'b1) begin errors++; $display("FAIL stop_ready got %b want 1", bus.rd_data[9]); end
    write_reg(5'd2, {21'b0, 3'd1, 8'h00});
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (scl !== 1'b1 || sda !== 1'b1 || bus.rd_data[9] !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL idle_wr_ignored got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_reset_mid;
    int   n, highs, e;
    bit   tout, done;
    logic ps;
    count_ready_low(n, tout);
    write_reg(5'd2, {21'b0, 3'd0, 8'h00});
    count_ready_low(n, tout);
    checks++; if (tout) begin errors++; $display("FAIL mid_start_timeout got timeout want ready"); end
    for (int k = 7; k >= 5; k--) exp_q.push_back(int'(8'h5A >> k) & 1);
    highs = 0; done = 1'b0; ps = scl;
    write_reg(5'd2, {21'b0, 3'd1, 8'h5A});
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (!ps && scl) begin
        e = exp_q.pop_front();
        checks++; if (int'(sda) !== e) begin errors++; $display("FAIL mid_bit%0d got %b want %0d", highs, sda, e); end
        highs++;
        if (highs == 1) begin
          write_reg(5'd2, {21'b0, 3'd3, 8'hFF});
          checks++; if (bus.rd_data[9] !== 1'b0) begin errors++; $display("FAIL busy_write got ready %b want 0", bus.rd_data[9]); end
        end
      end
      if (ps && !scl && highs == 3) begin
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (scl !== 1'b1 || sda !== 1'b1) begin errors++; $display("FAIL mid_reset_lines got %b%b want 11", scl, sda); end
        checks++; if (bus.rd_data !== 32'h0000_0200) begin errors++; $display("FAIL mid_reset_rd got %h want 00000200", bus.rd_data); end
        rst_n = 1'b1;
        done = 1'b1;
      end
      ps = scl;
    end
    checks++; if (!done) begin errors++; $display("FAIL mid_timeout got no bit 3 want reset point"); end
  endtask

  task automatic test_dvsr0;
    int  n, e;
    bit  tout;
    exp_q.push_back(2);
    exp_q.push_back(3);
    exp_q.push_back(3);
    write_reg(5'd2, {21'b0, 3'd0, 8'h00});
    count_ready_low(n, tout);
    e = exp_q.pop_front();
    checks++; if (tout || n !== e) begin errors++; $display("FAIL dvsr0_start got %0d want %0d", n, e); end
    write_reg(5'd2, {21'b0, 3'd4, 8'h00});
    count_ready_low(n, tout);
    e = exp_q.pop_front();
    checks++; if (tout || n !== e) begin errors++; $display("FAIL dvsr0_restart got %0d want %0d", n, e); end
    write_reg(5'd2, {21'b0, 3'd0, 8'h00});
    count_ready_low(n, tout);
    e = exp_q.pop_front();
    checks++; if (tout || n !== e) begin errors++; $display("FAIL hold_start got %0d want %0d", n, e); end
  endtask

  initial begin
    bus.cs = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
    bus.addr = 5'd0; bus.wr_data = 32'd0;
    slv_pull = 1'b0;
    rst_n = 1'b0;
    test_reset;
    test_start;
    test_wr;
    test_rd;
    test_stop;
    test_reset_mid;
    test_dvsr0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
